// File: rtl/fx_bus_pkg.sv
// fx_bus_pkg
//   Shared definitions for the fx register bus command master: frame header
//   codes, the write-acknowledge byte, fx field widths, the master FSM state
//   type and a saturating error-counter helper.
package fx_bus_pkg;

    localparam logic [7:0] HDR_WR = 8'hA5;
    localparam logic [7:0] HDR_RD = 8'h5A;
    localparam logic [7:0] ACK    = 8'h06;

    localparam int unsigned FX_AW = 16;   // fx address: [13:8] module id, [7:0] register
    localparam int unsigned FX_DW = 8;    // fx data
    localparam int unsigned CNT_W = 16;   // shared timeout / read-latency counter

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_AH,
        ST_GET_AL,
        ST_GET_D,
        ST_WR,
        ST_RD,
        ST_RD_WAIT,
        ST_RSP
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/fx_cmd_master.sv
// fx_cmd_master
//   Host-side master of the fx register bus. Parses a byte stream of
//   HDR, ADDR_H, ADDR_L[, DATA] frames into single fx_wr / fx_rd strobes and
//   returns one response byte (read data, or ACK for writes when ACK_WR=1).
// Ports
//   clk_sys, rst          clock, synchronous active-high reset
//   cmd_vld/cmd_data/cmd_rdy   command byte stream in (transfer = vld & rdy)
//   rsp_vld/rsp_data/rsp_rdy   response byte out (transfer = vld & rdy)
//   fx_waddr/fx_wr/fx_data     fx write port, one-cycle strobe, addr/data hold
//   fx_raddr/fx_rd/fx_q        fx read port, fx_q valid RD_LAT cycles after fx_rd
//   busy                  high whenever the FSM is not idle
//   err_cnt               saturating count of bad headers and timeouts
// Parameters
//   RD_LAT   fx read latency in cycles (must be >= 1)
//   TMO_CYC  idle cycles allowed inside a frame before abort; 0 disables
//   ACK_WR   1: writes return ACK, 0: writes return nothing
module fx_cmd_master
    import fx_bus_pkg::*;
#(
    parameter int unsigned RD_LAT  = 1,
    parameter int unsigned TMO_CYC = 1023,
    parameter bit          ACK_WR  = 1'b1
) (
    input  logic             clk_sys,
    input  logic             rst,
    input  logic             cmd_vld,
    input  logic [7:0]       cmd_data,
    output logic             cmd_rdy,
    output logic             rsp_vld,
    output logic [7:0]       rsp_data,
    input  logic             rsp_rdy,
    output logic [FX_AW-1:0] fx_waddr,
    output logic             fx_wr,
    output logic [FX_DW-1:0] fx_data,
    output logic [FX_AW-1:0] fx_raddr,
    output logic             fx_rd,
    input  logic [FX_DW-1:0] fx_q,
    output logic             busy,
    output logic [7:0]       err_cnt
);

    localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TMO_CYC);
    localparam logic [CNT_W-1:0] RD_LIM  = CNT_W'(RD_LAT - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_rd_q, is_rd_d;
    logic [7:0]         addr_h_q, addr_h_d;
    logic [7:0]         addr_l_q, addr_l_d;
    logic               cmd_rdy_q, cmd_rdy_d;
    logic               rsp_vld_q, rsp_vld_d;
    logic [7:0]         rsp_data_q, rsp_data_d;
    logic [FX_AW-1:0]   fx_waddr_q, fx_waddr_d;
    logic               fx_wr_q, fx_wr_d;
    logic [FX_DW-1:0]   fx_data_q, fx_data_d;
    logic [FX_AW-1:0]   fx_raddr_q, fx_raddr_d;
    logic               fx_rd_q, fx_rd_d;
    logic               busy_q, busy_d;
    logic [7:0]         err_cnt_q, err_cnt_d;
    logic               accept;

    assign accept = cmd_vld & cmd_rdy_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_rd_d    = is_rd_q;
        addr_h_d   = addr_h_q;
        addr_l_d   = addr_l_q;
        rsp_vld_d  = rsp_vld_q;
        rsp_data_d = rsp_data_q;
        fx_waddr_d = fx_waddr_q;
        fx_wr_d    = 1'b0;
        fx_data_d  = fx_data_q;
        fx_raddr_d = fx_raddr_q;
        fx_rd_d    = 1'b0;
        err_cnt_d  = err_cnt_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    if (cmd_data == HDR_WR) begin
                        is_rd_d = 1'b0;
                        state_d = ST_GET_AH;
                    end else if (cmd_data == HDR_RD) begin
                        is_rd_d = 1'b1;
                        state_d = ST_GET_AH;
                    end else begin
                        err_cnt_d = sat_inc8(err_cnt_q);
                    end
                end
            end
            ST_GET_AH: begin
                if (accept) begin
                    cnt_d    = '0;
                    addr_h_d = cmd_data;
                    state_d  = ST_GET_AL;
                end
            end
            ST_GET_AL: begin
                if (accept) begin
                    cnt_d = '0;
                    if (is_rd_q) begin
                        // Strobe is registered so it appears the cycle after ADDR_L.
                        fx_raddr_d = {addr_h_q, cmd_data};
                        fx_rd_d    = 1'b1;
                        state_d    = ST_RD;
                    end else begin
                        addr_l_d = cmd_data;
                        state_d  = ST_GET_D;
                    end
                end
            end
            ST_GET_D: begin
                if (accept) begin
                    cnt_d      = '0;
                    fx_waddr_d = {addr_h_q, addr_l_q};
                    fx_data_d  = cmd_data;
                    fx_wr_d    = 1'b1;
                    state_d    = ST_WR;
                end
            end
            ST_WR: begin
                if (ACK_WR) begin
                    rsp_vld_d  = 1'b1;
                    rsp_data_d = ACK;
                    state_d    = ST_RSP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                cnt_d   = '0;
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                // The counter is reused here to count off the slave read latency.
                if (cnt_q == RD_LIM) begin
                    cnt_d      = '0;
                    rsp_data_d = fx_q;
                    rsp_vld_d  = 1'b1;
                    state_d    = ST_RSP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RSP: begin
                if (rsp_rdy) begin
                    rsp_vld_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort lands on the edge where the idle count reaches the limit, so a
        // byte offered in that last cycle is still accepted rather than dropped.
        if ((state_q == ST_GET_AH || state_q == ST_GET_AL || state_q == ST_GET_D)
            && !accept && TMO_CYC != 0) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == TMO_LIM) begin
                cnt_d     = '0;
                state_d   = ST_IDLE;
                err_cnt_d = sat_inc8(err_cnt_q);
            end
        end

        cmd_rdy_d = (state_d == ST_IDLE) || (state_d == ST_GET_AH) ||
                    (state_d == ST_GET_AL) || (state_d == ST_GET_D);
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            is_rd_q    <= 1'b0;
            addr_h_q   <= '0;
            addr_l_q   <= '0;
            cmd_rdy_q  <= 1'b0;
            rsp_vld_q  <= 1'b0;
            rsp_data_q <= '0;
            fx_waddr_q <= '0;
            fx_wr_q    <= 1'b0;
            fx_data_q  <= '0;
            fx_raddr_q <= '0;
            fx_rd_q    <= 1'b0;
            busy_q     <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_rd_q    <= is_rd_d;
            addr_h_q   <= addr_h_d;
            addr_l_q   <= addr_l_d;
            cmd_rdy_q  <= cmd_rdy_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_data_q <= rsp_data_d;
            fx_waddr_q <= fx_waddr_d;
            fx_wr_q    <= fx_wr_d;
            fx_data_q  <= fx_data_d;
            fx_raddr_q <= fx_raddr_d;
            fx_rd_q    <= fx_rd_d;
            busy_q     <= busy_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign cmd_rdy  = cmd_rdy_q;
    assign rsp_vld  = rsp_vld_q;
    assign rsp_data = rsp_data_q;
    assign fx_waddr = fx_waddr_q;
    assign fx_wr    = fx_wr_q;
    assign fx_data  = fx_data_q;
    assign fx_raddr = fx_raddr_q;
    assign fx_rd    = fx_rd_q;
    assign busy     = busy_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_fx_cmd_master.sv
// tb_fx_cmd_master
//   Self-checking bench for fx_cmd_master: a transaction-level reference model
//   (frame byte queue, idle counter, post-frame phase) predicts every output on
//   every cycle; directed frames pin the model with literal expectations, then
//   randomized frames, gaps, response back-pressure and resets follow.
module tb_fx_cmd_master;

    localparam int unsigned TMO = 16;
    localparam int unsigned RDL = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_vld;
    logic [7:0]  cmd_data;
    logic        cmd_rdy;
    logic        rsp_vld;
    logic [7:0]  rsp_data;
    logic        rsp_rdy;
    logic [15:0] fx_waddr;
    logic        fx_wr;
    logic [7:0]  fx_data;
    logic [15:0] fx_raddr;
    logic        fx_rd;
    logic [7:0]  fx_q = 8'h00;
    logic        busy;
    logic [7:0]  err_cnt;

    logic rsp_rdy_dir;
    logic rdy_rand = 1'b1;
    bit   rand_mode = 1'b0;
    assign rsp_rdy = rand_mode ? rdy_rand : rsp_rdy_dir;

    always #5 clk = ~clk;

    fx_cmd_master #(.RD_LAT(RDL), .TMO_CYC(TMO), .ACK_WR(1'b1)) dut (
        .clk_sys (clk),
        .rst     (rst),
        .cmd_vld (cmd_vld),
        .cmd_data(cmd_data),
        .cmd_rdy (cmd_rdy),
        .rsp_vld (rsp_vld),
        .rsp_data(rsp_data),
        .rsp_rdy (rsp_rdy),
        .fx_waddr(fx_waddr),
        .fx_wr   (fx_wr),
        .fx_data (fx_data),
        .fx_raddr(fx_raddr),
        .fx_rd   (fx_rd),
        .fx_q    (fx_q),
        .busy    (busy),
        .err_cnt (err_cnt)
    );

    // Slave register content is a pure function of the address.
    function automatic logic [7:0] slave_val(input logic [15:0] a);
        return a[15:8] ^ a[7:0] ^ 8'hBD;
    endfunction

    // Single registered slave: q valid one cycle after fx_rd, 0 otherwise.
    always @(posedge clk) fx_q <= fx_rd ? slave_val(fx_raddr) : 8'h00;

    int unsigned n_chk = 0;
    int unsigned n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    bit          m_valid = 0;
    bit          m_just_rst = 0;
    logic [7:0]  m_bytes[$];
    int unsigned m_idle = 0;
    bit          m_exec = 0;
    bit          m_rd = 0;
    int unsigned m_phase = 0;
    bit          m_rsp = 0;
    logic [7:0]  m_rsp_b = 0;
    logic [15:0] m_waddr = 0, m_raddr = 0;
    logic [7:0]  m_data = 0, m_err = 0;

    always @(negedge clk) begin
        logic exp_rdy;
        logic acc;
        exp_rdy = !m_just_rst && !m_exec && !m_rsp;
        if (m_valid) begin
            chk("cmd_rdy",  cmd_rdy,  exp_rdy);
            chk("busy",     busy,     (m_bytes.size() > 0) || m_exec || m_rsp);
            chk("fx_wr",    fx_wr,    m_exec && !m_rd && m_phase == 0);
            chk("fx_rd",    fx_rd,    m_exec && m_rd && m_phase == 0);
            chk("rsp_vld",  rsp_vld,  m_rsp);
            if (m_rsp) chk("rsp_data", rsp_data, m_rsp_b);
            chk("fx_waddr", fx_waddr, m_waddr);
            chk("fx_data",  fx_data,  m_data);
            chk("fx_raddr", fx_raddr, m_raddr);
            chk("err_cnt",  err_cnt,  m_err);
        end
        if (rst) begin
            m_valid = 1; m_just_rst = 1;
            m_bytes.delete(); m_idle = 0; m_exec = 0; m_rd = 0; m_phase = 0;
            m_rsp = 0; m_rsp_b = 0; m_waddr = 0; m_raddr = 0; m_data = 0; m_err = 0;
        end else if (m_valid) begin
            acc = cmd_vld && exp_rdy;
            m_just_rst = 0;
            if (m_exec) begin
                if (!m_rd) begin
                    m_exec = 0; m_rsp = 1; m_rsp_b = 8'h06;
                end else if (m_phase == RDL) begin
                    m_exec = 0; m_rsp = 1; m_rsp_b = slave_val(m_raddr);
                end else begin
                    m_phase++;
                end
            end else if (m_rsp) begin
                if (rsp_rdy) m_rsp = 0;
            end else if (acc) begin
                m_bytes.push_back(cmd_data);
                m_idle = 0;
                if (m_bytes.size() == 1 && cmd_data != 8'hA5 && cmd_data != 8'h5A) begin
                    m_bytes.delete();
                    if (m_err != 8'hFF) m_err++;
                end else if (m_bytes[0] == 8'hA5 && m_bytes.size() == 4) begin
                    m_waddr = {m_bytes[1], m_bytes[2]}; m_data = m_bytes[3];
                    m_exec = 1; m_rd = 0; m_phase = 0; m_bytes.delete();
                end else if (m_bytes[0] == 8'h5A && m_bytes.size() == 3) begin
                    m_raddr = {m_bytes[1], m_bytes[2]};
                    m_exec = 1; m_rd = 1; m_phase = 0; m_bytes.delete();
                end
            end else if (m_bytes.size() > 0) begin
                m_idle++;
                if (m_idle == TMO) begin
                    m_bytes.delete(); m_idle = 0;
                    if (m_err != 8'hFF) m_err++;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    always begin
        @(posedge clk); #1;
        rdy_rand = ($urandom_range(0, 2) != 0);
    end

    task automatic sync();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [7:0] b);
        bit ok;
        ok = 0;
        cmd_vld = 1'b1; cmd_data = b;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cmd_rdy === 1'b1) begin ok = 1; break; end
        end
        if (!ok) begin
            n_chk++;
            $display("FAIL send_wait: cmd_rdy is %b, required 1 within 200 cycles", cmd_rdy);
        end
        @(posedge clk); #1;
        cmd_vld = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cmd_vld = 1'b0; cmd_data = 8'h00; rsp_rdy_dir = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("lit_rst_rdy", cmd_rdy, 1'b0);
        chk("lit_rst_err", err_cnt, 8'h00);
        sync(); sync();

        // back-to-back write: strobe in T4, ACK in T5
        send(8'hA5); send(8'h01); send(8'h80); send(8'h3C);
        @(negedge clk);
        chk("lit_wr_strobe", fx_wr, 1'b1);
        chk("lit_wr_addr", fx_waddr, 16'h0180);
        chk("lit_wr_data", fx_data, 8'h3C);
        @(negedge clk);
        chk("lit_ack_vld", rsp_vld, 1'b1);
        chk("lit_ack_data", rsp_data, 8'h06);
        sync();

        // back-to-back read: strobe in T3, data in T5
        send(8'h5A); send(8'h01); send(8'h80);
        @(negedge clk);
        chk("lit_rd_strobe", fx_rd, 1'b1);
        chk("lit_rd_addr", fx_raddr, 16'h0180);
        @(negedge clk);
        chk("lit_rd_early", rsp_vld, 1'b0);
        @(negedge clk);
        chk("lit_rd_vld", rsp_vld, 1'b1);
        chk("lit_rd_data", rsp_data, 8'h3C);
        sync();

        // read with response back-pressure
        rsp_rdy_dir = 1'b0;
        send(8'h5A); send(8'h12); send(8'h34);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("lit_stall_vld", rsp_vld, 1'b1);
            chk("lit_stall_data", rsp_data, 8'h9B);
            chk("lit_stall_rdy", cmd_rdy, 1'b0);
        end
        sync();
        rsp_rdy_dir = 1'b1;
        @(negedge clk);
        chk("lit_stall_last", rsp_vld, 1'b1);
        @(negedge clk);
        chk("lit_stall_done", rsp_vld, 1'b0);
        sync();

        // bad header then a normal read
        send(8'h00);
        send(8'h5A); send(8'h01); send(8'h80);
        @(negedge clk);
        chk("lit_bad_rd", fx_rd, 1'b1);
        repeat (2) @(negedge clk);
        chk("lit_bad_data", rsp_data, 8'h3C);
        chk("lit_bad_err", err_cnt, 8'h01);
        sync();

        // timeout after two bytes of a write frame
        send(8'hA5); send(8'h01);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 15) chk("lit_tmo_busy", busy, 1'b1);
            if (i == 16) begin
                chk("lit_tmo_abort", busy, 1'b0);
                chk("lit_tmo_err", err_cnt, 8'h02);
            end
        end
        sync();
        send(8'hA5); send(8'h02); send(8'h11); send(8'h77);
        @(negedge clk);
        chk("lit_tmo_next_wr", fx_wr, 1'b1);
        chk("lit_tmo_next_addr", fx_waddr, 16'h0211);
        sync(); sync();

        // error counter saturation
        for (int i = 0; i < 256; i++) send(8'h00);
        sync();
        @(negedge clk);
        chk("lit_err_sat", err_cnt, 8'hFF);
        sync();

        // reset coincident with the DATA byte
        send(8'hA5); send(8'h01); send(8'h80);
        cmd_vld = 1'b1; cmd_data = 8'h3C; rst = 1'b1;
        sync();
        rst = 1'b0; cmd_vld = 1'b0;
        @(negedge clk);
        chk("lit_mrst_wr", fx_wr, 1'b0);
        chk("lit_mrst_busy", busy, 1'b0);
        chk("lit_mrst_err", err_cnt, 8'h00);
        chk("lit_mrst_waddr", fx_waddr, 16'h0000);
        chk("lit_mrst_data", fx_data, 8'h00);
        chk("lit_mrst_rsp", rsp_vld, 1'b0);
        sync();

        // randomized frames, gaps, back-pressure and resets
        rand_mode = 1'b1;
        for (int f = 0; f < 400; f++) begin
            int unsigned kind;
            logic [7:0] fb[4];
            int unsigned nb;
            kind = $urandom_range(0, 19);
            fb[1] = 8'($urandom); fb[2] = 8'($urandom); fb[3] = 8'($urandom);
            if (kind == 0) begin
                rst = 1'b1; sync(); rst = 1'b0;
                nb = 0;
            end else if (kind < 3) begin
                fb[0] = 8'($urandom); nb = 1;
            end else if (kind < 11) begin
                fb[0] = 8'hA5; nb = 4;
            end else begin
                fb[0] = 8'h5A; nb = 3;
            end
            for (int k = 0; k < 4; k++) begin
                if (k < int'(nb)) begin
                    if ($urandom_range(0, 3) == 0) repeat ($urandom_range(0, 22)) sync();
                    send(fb[k]);
                end
            end
        end
        rand_mode = 1'b0;
        rsp_rdy_dir = 1'b1;
        repeat (30) sync();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
